xlr8_prbs_chk: RTL and testbench
================================

// Module: xlr8_prbs_chk
// PURPOSE
//  XB-style PRBS checker; receive-side counterpart of the XLR8 LFSR generator XB.
//  CPU writes received bytes to DATA. The block self-synchronises its own LFSR to the stream,
//  confirms lock, then counts byte mismatches. Sits on the data-memory register bus.
// PARAMETERS
//  PRBS_CTRL_ADDR  0      CTRL register address (ramadr)
//  PRBS_DATA_ADDR  0      DATA register address
//  PRBS_STAT_ADDR  0      STAT register address
//  PRBS_ERRL_ADDR  0      error count low byte
//  PRBS_ERRH_ADDR  0      error count high byte (shadow)
//  TAPS            8'hB8  Fibonacci feedback mask; step(s) = {s[6:0], ^(s & TAPS)}
//  LOCK_CNT        4      consecutive matches needed for lock (1..15)
//  LOSS_CNT        3      consecutive LOCKED mismatches that drop lock (0 = never drop)
// PORTS
//  clk        in   1  clock
//  rstn       in   1  asynchronous active-low reset
//  clken      in   1  qualifies all register writes and state updates
//  dbus_in    in   8  write data
//  dbus_out   out  8  read data: mux of selected register, 0 when no register selected
//  io_out_en  out  1  high when ramre is asserted with a register of this block selected
//  ramadr     in   8  register address
//  ramre      in   1  read strobe
//  ramwe      in   1  write strobe
//  dm_sel     in   1  data-memory select
//  irq        out  1  interrupt; tied 0 when the optional feature is compiled out
// BEHAVIOUR
//  Reset: every register is 0. State is DISABLED. irq=0, io_out_en=0.
//  Decode is sel = dm_sel && ramadr==ADDR. Writes take effect at the clk edge with clken && we.
//  Only one register is accessed per cycle, so register accesses never collide.
//  CTRL (RW):
//   - b0 EN: reads back.
//   - b1 RESYNC: self-clearing; forces SYNC and clears both match and miss counts; reads 0.
//   - b2 CLR_ERR: self-clearing; clears the error count and err_sat; reads 0.
//  STAT (RO): b[1:0] state (0 DISABLED, 1 SYNC, 2 CONFIRM, 3 LOCKED); b2 err_sat.
//  DATA: a write feeds the checker. A read returns the current expected-state register.
//  ERRL/ERRH: 16-bit error count.
//   - Reading ERRL returns the low byte and latches the high byte into a shadow.
//   - Reading ERRH returns the shadow.
//  FSM: updates on a DATA write only. CTRL transitions apply on CTRL writes.
//   - EN=0 -> DISABLED; DATA writes ignored.
//   - EN 0->1 -> SYNC.
//   - SYNC: byte==0 is ignored (lockup value). Otherwise exp<=byte, mcnt<=0, go to CONFIRM.
//   - CONFIRM: byte==step(exp) counts as a match: exp<=byte, mcnt++.
//     When mcnt reaches LOCK_CNT -> LOCKED, miss<=0.
//     On mismatch: exp<=byte (reseed), mcnt<=0, stay in CONFIRM. Errors are not counted.
//   - LOCKED: exp<=step(exp) always (flywheel, no reseed).
//     Match -> miss<=0.
//     Mismatch -> err++ (saturates at 16'hFFFF, sets err_sat), miss++.
//     When miss reaches LOSS_CNT (if LOSS_CNT!=0) -> SYNC.
//  Latency: STAT, ERR and DATA readback reflect a DATA write on the cycle after it.
//  Reset asserted mid-stream: immediate return to reset values; the shadow is cleared.
// CONFIGURATION
//  Macro XLR8_PRBS_CHK_IRQ_EN.
//  Defined:
//   - CTRL b3 IRQ_EN (RW). STAT b3 pend.
//   - pend is set on LOCKED->SYNC (lock loss) and on err_sat rising.
//   - Writing 1 to STAT b3 clears pend (W1C); a set in the same cycle wins.
//   - irq = pend && IRQ_EN.
//  Undefined: CTRL b3 and STAT b3 read 0; irq constant 0; no flops are added.
// STRUCTURE
//  Package xlr8_prbs_chk_pkg: state enum, CTRL/STAT bit-position constants,
//   function lfsr_step(state, taps).
//  Sub-module xlr8_prbs_chk_core: FSM, exp register, match/miss/error counters.
//  Top level: address decode, CTRL, ERRH shadow, read mux, irq logic.
// TESTING (TAPS=B8: 01->02->04->08->11->23->47; LOCK_CNT=4, LOSS_CNT=3)
//  1 EN=1; write DATA 01,02,04,08,11 -> STAT=1,2,2,2,2 then 3 (LOCKED); ERR=0.
//  2 From LOCKED after 11: write 00 then 47 -> ERRL=01, state stays 3, DATA read=47.
//  3 LOCKED: write 3 wrong bytes -> state 1 (SYNC), ERRL=03; then write 00 -> stays 1.
//  4 LOSS_CNT=0: 65540 mismatches -> ERRL=FF, ERRH=FF, err_sat=1, still LOCKED.
//    Then CLR_ERR -> ERR=0, err_sat=0.
//  5 ERR=0x01FF: read ERRL=FF, add 1 error, read ERRH -> 01 (shadow).
//    Unselected read -> io_out_en=0, dbus_out=00.
//  6 IRQ_EN build: lock loss -> irq=1; W1C STAT b3 -> irq=0.
//    Pulse rstn mid-stream -> all registers 0, irq=0.

Source files
------------

// File: rtl/xlr8_prbs_chk_pkg.sv
// Shared types and helpers for the XLR8 PRBS checker.
package xlr8_prbs_chk_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_CONFIRM  = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RESYNC  = 1;
  localparam int CTRL_CLR_ERR = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_ERR_SAT = 2;
  localparam int STAT_PEND    = 3;

  // Fibonacci LFSR: shift left, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] taps);
    return {s[6:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/xlr8_prbs_chk_if.sv
// Data-memory register bus between the CPU side (master) and the PRBS checker (slave).
interface xlr8_prbs_chk_if;
  logic       clken;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;
  logic       irq;

  modport master (
    output clken, dbus_in, ramadr, ramre, ramwe, dm_sel,
    input  dbus_out, io_out_en, irq
  );

  modport slave (
    input  clken, dbus_in, ramadr, ramre, ramwe, dm_sel,
    output dbus_out, io_out_en, irq
  );
endinterface

// File: rtl/xlr8_prbs_chk_core.sv
// PRBS checker core: sync/confirm/locked FSM, expected-state register, match, miss and error counters.
module xlr8_prbs_chk_core
  import xlr8_prbs_chk_pkg::*;
#(
  parameter logic [7:0] TAPS     = 8'hB8,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_ctrl_wr,
  input  logic        i_en_cur,
  input  logic        i_en_new,
  input  logic        i_resync,
  input  logic        i_clr_err,
  input  logic        i_data_wr,
  input  logic [7:0]  i_data,
  output state_t      o_state,
  output logic [7:0]  o_exp,
  output logic [15:0] o_err,
  output logic        o_err_sat,
  output logic        o_lock_lost,
  output logic        o_sat_rise
);

  state_t      r_state;
  logic [7:0]  r_exp;
  logic [3:0]  r_mcnt;
  logic [7:0]  r_miss;
  logic [15:0] r_err;
  logic        r_err_sat;

  logic [7:0] w_step;
  logic       w_match;
  logic       w_lock_err;
  logic       w_loss;

  assign w_step     = lfsr_step(r_exp, TAPS);
  assign w_match    = (i_data == w_step);
  assign w_lock_err = i_data_wr && (r_state == ST_LOCKED) && !w_match;
  assign w_loss     = w_lock_err && (LOSS_CNT != 0) && (r_miss == 8'(LOSS_CNT - 1));

  assign o_sat_rise  = w_lock_err && (r_err == 16'hFFFE);
  assign o_lock_lost = w_loss ||
                       (i_ctrl_wr && i_en_new && i_resync && (r_state == ST_LOCKED));

  // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_DISABLED;
      r_exp     <= 8'h00;
      r_mcnt    <= 4'd0;
      r_miss    <= 8'd0;
      r_err     <= 16'h0000;
      r_err_sat <= 1'b0;
    end else if (i_ctrl_wr) begin
      if (!i_en_new) begin
        r_state <= ST_DISABLED;
      end else if (!i_en_cur || i_resync) begin
        r_state <= ST_SYNC;
        r_mcnt  <= 4'd0;
        r_miss  <= 8'd0;
      end
      if (i_clr_err) begin
        r_err     <= 16'h0000;
        r_err_sat <= 1'b0;
      end
    end else if (i_data_wr) begin
      case (r_state)
        ST_SYNC: begin
          if (i_data != 8'h00) begin
            r_exp   <= i_data;
            r_mcnt  <= 4'd0;
            r_state <= ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          r_exp <= i_data;
          if (w_match) begin
            r_mcnt <= r_mcnt + 4'd1;
            if (r_mcnt == 4'(LOCK_CNT - 1)) begin
              r_state <= ST_LOCKED;
              r_miss  <= 8'd0;
            end
          end else begin
            r_mcnt <= 4'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: once locked the expected sequence free-runs, never reseeded by received data.
          r_exp <= w_step;
          if (w_match) begin
            r_miss <= 8'd0;
          end else begin
            r_miss <= r_miss + 8'd1;
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (o_sat_rise) r_err_sat <= 1'b1;
            if (w_loss) r_state <= ST_SYNC;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_exp     = r_exp;
  assign o_err     = r_err;
  assign o_err_sat = r_err_sat;

endmodule

// File: rtl/xlr8_prbs_chk.sv
// XLR8 PRBS checker top: register decode, CTRL, ERRH shadow, read mux and irq.
// Optional interrupt support is compiled in with macro XLR8_PRBS_CHK_IRQ_EN.
module xlr8_prbs_chk
  import xlr8_prbs_chk_pkg::*;
#(
  parameter logic [7:0] PRBS_CTRL_ADDR = 8'h00,
  parameter logic [7:0] PRBS_DATA_ADDR = 8'h00,
  parameter logic [7:0] PRBS_STAT_ADDR = 8'h00,
  parameter logic [7:0] PRBS_ERRL_ADDR = 8'h00,
  parameter logic [7:0] PRBS_ERRH_ADDR = 8'h00,
  parameter logic [7:0] TAPS           = 8'hB8,
  parameter int         LOCK_CNT       = 4,
  parameter int         LOSS_CNT       = 3
) (
  input logic             clk,
  input logic             rstn,
  xlr8_prbs_chk_if.slave  bus
);

  logic w_sel_ctrl, w_sel_data, w_sel_stat, w_sel_errl, w_sel_errh, w_sel_any;
  logic w_wr, w_ctrl_wr, w_data_wr, w_errl_rd;

  assign w_sel_ctrl = bus.dm_sel && (bus.ramadr == PRBS_CTRL_ADDR);
  assign w_sel_data = bus.dm_sel && (bus.ramadr == PRBS_DATA_ADDR);
  assign w_sel_stat = bus.dm_sel && (bus.ramadr == PRBS_STAT_ADDR);
  assign w_sel_errl = bus.dm_sel && (bus.ramadr == PRBS_ERRL_ADDR);
  assign w_sel_errh = bus.dm_sel && (bus.ramadr == PRBS_ERRH_ADDR);
  assign w_sel_any  = w_sel_ctrl | w_sel_data | w_sel_stat | w_sel_errl | w_sel_errh;

  assign w_wr      = bus.clken && bus.ramwe;
  assign w_ctrl_wr = w_wr && w_sel_ctrl;
  assign w_data_wr = w_wr && w_sel_data;
  assign w_errl_rd = bus.clken && bus.ramre && w_sel_errl;

  state_t      w_state;
  logic [7:0]  w_exp;
  logic [15:0] w_err;
  logic        w_err_sat, w_lock_lost, w_sat_rise;
  logic        r_en;
  logic [7:0]  r_shadow;

  // Reading ERRL freezes the high byte so a 16-bit count reads coherently across two accesses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en     <= 1'b0;
      r_shadow <= 8'h00;
    end else begin
      if (w_ctrl_wr) r_en     <= bus.dbus_in[CTRL_EN];
      if (w_errl_rd) r_shadow <= w_err[15:8];
    end
  end

  xlr8_prbs_chk_core #(
    .TAPS     (TAPS),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_core (
    .clk         (clk),
    .rstn        (rstn),
    .i_ctrl_wr   (w_ctrl_wr),
    .i_en_cur    (r_en),
    .i_en_new    (bus.dbus_in[CTRL_EN]),
    .i_resync    (bus.dbus_in[CTRL_RESYNC]),
    .i_clr_err   (bus.dbus_in[CTRL_CLR_ERR]),
    .i_data_wr   (w_data_wr),
    .i_data      (bus.dbus_in),
    .o_state     (w_state),
    .o_exp       (w_exp),
    .o_err       (w_err),
    .o_err_sat   (w_err_sat),
    .o_lock_lost (w_lock_lost),
    .o_sat_rise  (w_sat_rise)
  );

  logic w_irq_en, w_pend;

`ifdef XLR8_PRBS_CHK_IRQ_EN
  logic w_stat_wr;
  logic r_irq_en, r_pend;

  assign w_stat_wr = w_wr && w_sel_stat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_irq_en <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.dbus_in[CTRL_IRQ_EN];
      if (w_lock_lost || w_sat_rise)                r_pend <= 1'b1;
      else if (w_stat_wr && bus.dbus_in[STAT_PEND]) r_pend <= 1'b0;
    end
  end

  assign w_irq_en = r_irq_en;
  assign w_pend   = r_pend;
`else
  logic w_unused_irq;
  assign w_unused_irq = &{1'b0, w_lock_lost, w_sat_rise};
  assign w_irq_en     = 1'b0;
  assign w_pend       = 1'b0;
`endif

  logic [7:0] w_rdata;

  // NOTE: default assignment first so every path drives w_rdata and no latch is inferred.
  always_comb begin
    w_rdata = 8'h00;
    if (w_sel_ctrl) begin
      w_rdata[CTRL_EN]     = r_en;
      w_rdata[CTRL_IRQ_EN] = w_irq_en;
    end else if (w_sel_stat) begin
      w_rdata[1:0]          = w_state;
      w_rdata[STAT_ERR_SAT] = w_err_sat;
      w_rdata[STAT_PEND]    = w_pend;
    end else if (w_sel_data) begin
      w_rdata = w_exp;
    end else if (w_sel_errl) begin
      w_rdata = w_err[7:0];
    end else if (w_sel_errh) begin
      w_rdata = r_shadow;
    end
  end

  assign bus.dbus_out  = w_rdata;
  assign bus.io_out_en = bus.ramre && w_sel_any;
  assign bus.irq       = w_pend && w_irq_en;

endmodule

// File: tb/tb_xlr8_prbs_chk.sv
// Self-checking bench for xlr8_prbs_chk: two instances (LOSS_CNT=3 and LOSS_CNT=0) against a behavioural model.
module tb_xlr8_prbs_chk;

  localparam logic [7:0] A_CTRL = 8'h20;
  localparam logic [7:0] A_DATA = 8'h21;
  localparam logic [7:0] A_STAT = 8'h22;
  localparam logic [7:0] A_ERRL = 8'h23;
  localparam logic [7:0] A_ERRH = 8'h24;
  localparam logic [7:0] TAPS   = 8'hB8;
  localparam int LOCK_CNT = 4;
  localparam int LOSS0    = 3;
  localparam int LOSS1    = 0;

`ifdef XLR8_PRBS_CHK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [7:0] PEND_LIT = IRQ ? 8'h08 : 8'h00;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clken = 1'b0, ramwe = 1'b0, ramre = 1'b0, dm_sel = 1'b0;
  logic [7:0] dbus_in = 8'h00, ramadr = 8'h00;
  int         tgt = 0;

  always #5 clk = ~clk;

  xlr8_prbs_chk_if bus0 ();
  xlr8_prbs_chk_if bus1 ();

  assign bus0.clken   = clken;
  assign bus0.dbus_in = dbus_in;
  assign bus0.ramadr  = ramadr;
  assign bus0.ramre   = ramre;
  assign bus0.ramwe   = ramwe;
  assign bus0.dm_sel  = dm_sel && (tgt == 0);
  assign bus1.clken   = clken;
  assign bus1.dbus_in = dbus_in;
  assign bus1.ramadr  = ramadr;
  assign bus1.ramre   = ramre;
  assign bus1.ramwe   = ramwe;
  assign bus1.dm_sel  = dm_sel && (tgt == 1);

  xlr8_prbs_chk #(
    .PRBS_CTRL_ADDR(A_CTRL), .PRBS_DATA_ADDR(A_DATA), .PRBS_STAT_ADDR(A_STAT),
    .PRBS_ERRL_ADDR(A_ERRL), .PRBS_ERRH_ADDR(A_ERRH),
    .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS0)
  ) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));

  xlr8_prbs_chk #(
    .PRBS_CTRL_ADDR(A_CTRL), .PRBS_DATA_ADDR(A_DATA), .PRBS_STAT_ADDR(A_STAT),
    .PRBS_ERRL_ADDR(A_ERRL), .PRBS_ERRH_ADDR(A_ERRH),
    .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS1)
  ) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       en, irq_en, sat, pend;
    logic [1:0] st;
    logic [7:0] exp, shadow;
    int         mcnt, miss, err;
  } mdl_t;

  mdl_t m [2];
  int   loss [2] = '{LOSS0, LOSS1};

  function automatic logic [7:0] mstep(input logic [7:0] s);
    logic fb = 1'b0;
    for (int i = 0; i < 8; i++) if (TAPS[i]) fb ^= s[i];
    return {s[6:0], fb};
  endfunction

  task automatic model_op(input int k);
    mdl_t s = m[k];
    logic [1:0] st0 = m[k].st;
    logic sat0 = m[k].sat;
    logic [7:0] nx = mstep(m[k].exp);
    if (ramwe) begin
      if (ramadr == A_CTRL) begin
        if (!dbus_in[0]) s.st = 2'd0;
        else if (!s.en || dbus_in[1]) begin s.st = 2'd1; s.mcnt = 0; s.miss = 0; end
        if (dbus_in[2]) begin s.err = 0; s.sat = 1'b0; end
        s.en = dbus_in[0];
        s.irq_en = IRQ && dbus_in[3];
      end else if (ramadr == A_DATA && s.st != 2'd0) begin
        case (s.st)
          2'd1: if (dbus_in != 8'h00) begin s.exp = dbus_in; s.mcnt = 0; s.st = 2'd2; end
          2'd2: begin
            if (dbus_in == nx) begin
              s.mcnt = s.mcnt + 1;
              if (s.mcnt == LOCK_CNT) begin s.st = 2'd3; s.miss = 0; end
            end else s.mcnt = 0;
            s.exp = dbus_in;
          end
          default: begin
            s.exp = nx;
            if (dbus_in == nx) s.miss = 0;
            else begin
              if (s.err < 65535) s.err = s.err + 1;
              if (s.err == 65535) s.sat = 1'b1;
              s.miss = s.miss + 1;
              if (loss[k] != 0 && s.miss == loss[k]) s.st = 2'd1;
            end
          end
        endcase
      end else if (ramadr == A_STAT && dbus_in[3]) s.pend = 1'b0;
    end
    if (ramre && ramadr == A_ERRL) s.shadow = m[k].err[15:8];
    if (IRQ && ((st0 == 2'd3 && s.st == 2'd1) || (!sat0 && s.sat))) s.pend = 1'b1;
    m[k] = s;
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      m[0] = '0;
      m[1] = '0;
    end else if (clken && dm_sel) model_op(tgt);
  end

  function automatic logic [9:0] exp_out(input int k);
    mdl_t mm = rstn ? m[k] : '0;
    logic [7:0] v = 8'h00;
    logic hit = dm_sel && (tgt == k);
    if (hit) begin
      case (ramadr)
        A_CTRL:  v = {4'b0, mm.irq_en, 2'b00, mm.en};
        A_STAT:  v = {4'b0, mm.pend, mm.sat, mm.st};
        A_DATA:  v = mm.exp;
        A_ERRL:  v = mm.err[7:0];
        A_ERRH:  v = mm.shadow;
        default: hit = 1'b0;
      endcase
    end
    return {v, hit && ramre, mm.pend && mm.irq_en};
  endfunction

  always @(negedge clk) begin
    check("bus0 {dbus_out,io_out_en,irq}", {22'b0, bus0.dbus_out, bus0.io_out_en, bus0.irq}, {22'b0, exp_out(0)});
    check("bus1 {dbus_out,io_out_en,irq}", {22'b0, bus1.dbus_out, bus1.io_out_en, bus1.irq}, {22'b0, exp_out(1)});
  end

  // ---------------- stimulus ----------------
  logic [7:0] cap_d;
  logic       cap_oe, cap_irq;

  task automatic op(input int t, input logic sel, input logic we, input logic re,
                    input logic [7:0] adr, input logic [7:0] d);
    tgt = t; dm_sel = sel; ramwe = we; ramre = re; ramadr = adr; dbus_in = d; clken = 1'b1;
    @(negedge clk);
    cap_d   = (t == 0) ? bus0.dbus_out  : bus1.dbus_out;
    cap_oe  = (t == 0) ? bus0.io_out_en : bus1.io_out_en;
    cap_irq = (t == 0) ? bus0.irq       : bus1.irq;
    @(posedge clk); #1;
    dm_sel = 1'b0; ramwe = 1'b0; ramre = 1'b0;
  endtask

  task automatic wr(input int t, input logic [7:0] adr, input logic [7:0] d);
    op(t, 1'b1, 1'b1, 1'b0, adr, d);
  endtask

  task automatic rd(input int t, input logic [7:0] adr);
    op(t, 1'b1, 1'b0, 1'b1, adr, 8'h00);
  endtask

  function automatic logic [7:0] bad_byte(input int k);
    logic [7:0] b = 8'($urandom);
    if (b == mstep(m[k].exp)) b = b ^ 8'h01;
    return b;
  endfunction

  logic [7:0] seq [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  logic [7:0] stat_after [5] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h03};
  logic [7:0] addrs [5] = '{A_CTRL, A_DATA, A_STAT, A_ERRL, A_ERRH};

  initial begin
    logic [7:0] g;
    int r;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      rd(0, addrs[i]);
      check("reset reg", cap_d, 8'h00);
    end
    check("reset irq", cap_irq, 1'b0);

    // Acquire lock on the canonical sequence.
    wr(0, A_CTRL, 8'h01);
    rd(0, A_STAT); check("stat after enable", cap_d, 8'h01);
    for (int i = 0; i < 5; i++) begin
      wr(0, A_DATA, seq[i]);
      rd(0, A_STAT); check("stat during sync", cap_d, stat_after[i]);
    end
    rd(0, A_ERRL); check("errl after lock", cap_d, 8'h00);

    // Flywheel across one bad byte.
    wr(0, A_DATA, 8'h00);
    wr(0, A_DATA, 8'h47);
    rd(0, A_ERRL); check("errl one error", cap_d, 8'h01);
    rd(0, A_STAT); check("stat still locked", cap_d, 8'h03);
    rd(0, A_DATA); check("data readback", cap_d, 8'h47);
    check("data io_out_en", cap_oe, 1'b1);

    wr(0, A_CTRL, 8'h05);
    rd(0, A_ERRL); check("errl after clr", cap_d, 8'h00);

    // Lose lock after three misses; zero byte ignored in SYNC.
    repeat (3) wr(0, A_DATA, 8'h00);
    rd(0, A_STAT); check("stat after loss", cap_d, 8'h01 | PEND_LIT);
    rd(0, A_ERRL); check("errl three errors", cap_d, 8'h03);
    wr(0, A_DATA, 8'h00);
    rd(0, A_STAT); check("stat zero ignored", cap_d, 8'h01 | PEND_LIT);

`ifdef XLR8_PRBS_CHK_IRQ_EN
    wr(0, A_CTRL, 8'h09);
    rd(0, A_STAT); check("irq pending stat", cap_d, 8'h09);
    check("irq asserted", cap_irq, 1'b1);
    wr(0, A_STAT, 8'h08);
    rd(0, A_STAT); check("w1c stat", cap_d, 8'h01);
    check("irq cleared", cap_irq, 1'b0);
    for (int i = 0; i < 5; i++) wr(0, A_DATA, seq[i]);
    rd(0, A_STAT); check("relock", cap_d, 8'h03);
    repeat (3) wr(0, A_DATA, 8'h00);
    rd(0, A_STAT); check("loss pend", cap_d, 8'h09);
    check("irq on loss", cap_irq, 1'b1);
    wr(0, A_STAT, 8'h08);
    rd(0, A_STAT); check("irq w1c", cap_irq, 1'b0);
`endif

    // Randomized traffic on instance 0.
    g = 8'($urandom_range(1, 255));
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin g = mstep(g); wr(0, A_DATA, g); end
      else if (r < 80) wr(0, A_DATA, 8'($urandom));
      else if (r < 90) rd(0, addrs[$urandom_range(0, 4)]);
      else if (r < 94) wr(0, A_CTRL, {4'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                                       1'($urandom_range(0, 2) == 0), 1'b1});
      else if (r < 96) wr(0, A_CTRL, 8'h00);
      else wr(0, A_STAT, 8'($urandom));
    end

    // Reset mid-stream.
    wr(0, A_CTRL, 8'h09);
    for (int i = 0; i < 5; i++) wr(0, A_DATA, seq[i]);
    wr(0, A_DATA, 8'h00);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(0, addrs[i]);
      check("post-reset reg", cap_d, 8'h00);
    end
    check("post-reset irq", cap_irq, 1'b0);

    // Instance 1: no lock drop, shadow coherence, saturation.
    wr(1, A_CTRL, 8'h01);
    for (int i = 0; i < 5; i++) wr(1, A_DATA, seq[i]);
    rd(1, A_STAT); check("inst1 locked", cap_d, 8'h03);
    repeat (511) wr(1, A_DATA, bad_byte(1));
    rd(1, A_ERRL); check("errl 0x1ff", cap_d, 8'hFF);
    wr(1, A_DATA, bad_byte(1));
    rd(1, A_ERRH); check("errh shadow", cap_d, 8'h01);
    rd(1, A_ERRL); check("errl 0x200", cap_d, 8'h00);
    rd(1, A_ERRH); check("errh 0x200", cap_d, 8'h02);
    op(1, 1'b0, 1'b0, 1'b1, A_ERRL, 8'h00);
    check("unselected dbus_out", cap_d, 8'h00);
    check("unselected io_out_en", cap_oe, 1'b0);
    op(1, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h00);
    check("unmapped dbus_out", cap_d, 8'h00);
    check("unmapped io_out_en", cap_oe, 1'b0);
    repeat (65540 - 512) wr(1, A_DATA, bad_byte(1));
    rd(1, A_ERRL); check("errl saturated", cap_d, 8'hFF);
    rd(1, A_ERRH); check("errh saturated", cap_d, 8'hFF);
    rd(1, A_STAT); check("stat saturated", cap_d, 8'h07 | PEND_LIT);
    wr(1, A_CTRL, 8'h05);
    rd(1, A_ERRL); check("errl cleared", cap_d, 8'h00);
    rd(1, A_ERRH); check("errh cleared", cap_d, 8'h00);
    rd(1, A_STAT); check("stat sat cleared", cap_d, 8'h03 | PEND_LIT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
